eth_rx_ctrl: RTL and testbench

ETH_RX_CTRL -- requirements
Module: eth_rx_ctrl

---
 rtl/eth_pkg.sv | 37 +++
 rtl/eth_rx_ctrl_if.sv | 24 ++
 rtl/eth_clk_en_gen.sv | 27 ++
 rtl/eth_rx_ctrl.sv | 132 +++++++++++++
 tb/tb_eth_rx_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared state, speed and divider encodings for the receive controller
package eth_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  localparam int DIV_W = 6;
  localparam logic [DIV_W-1:0] RATIO_1000 = 6'd1;
  localparam logic [DIV_W-1:0] RATIO_100  = 6'd5;
  localparam logic [DIV_W-1:0] RATIO_10   = 6'd50;

  // The reserved code 2'b11 behaves as gigabit everywhere.
  function automatic logic [1:0] norm_speed(input logic [1:0] s);
    return (s == 2'b11) ? SPEED_1000 : s;
  endfunction

  function automatic logic [DIV_W-1:0] speed_ratio(input logic [1:0] s);
    case (s)
      SPEED_100: return RATIO_100;
      SPEED_10:  return RATIO_10;
      default:   return RATIO_1000;
    endcase
  endfunction

  function automatic logic speed_is_mii(input logic [1:0] s);
    return (s == SPEED_100) || (s == SPEED_10);
  endfunction

endpackage

// File: rtl/eth_rx_ctrl_if.sv
// rtl/eth_rx_ctrl_if.sv - monitor and control signals between the GMII receiver and its controller
interface eth_rx_ctrl_if;

  logic rx_dv;
  logic rx_tvalid;
  logic rx_tlast;
  logic rx_tuser;
  logic start_packet;
  logic error_bad_fcs;
  logic clk_enable;
  logic mii_select;
  logic rx_cfg_enable;

  modport master (
    output rx_dv, rx_tvalid, rx_tlast, rx_tuser, start_packet, error_bad_fcs,
    input  clk_enable, mii_select, rx_cfg_enable
  );

  modport slave (
    input  rx_dv, rx_tvalid, rx_tlast, rx_tuser, start_packet, error_bad_fcs,
    output clk_enable, mii_select, rx_cfg_enable
  );

endinterface

// File: rtl/eth_clk_en_gen.sv
// rtl/eth_clk_en_gen.sv - clock-enable strobe generator, one pulse every ratio cycles
module eth_clk_en_gen
  import eth_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] ratio,
  input  logic             load,
  output logic             clk_enable
);

  logic [DIV_W-1:0] cnt;

  // load restarts the phase so the first strobe lands right after a speed change.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (cnt >= ratio - 1'b1) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign clk_enable = (cnt == '0);

endmodule

// File: rtl/eth_rx_ctrl.sv
// rtl/eth_rx_ctrl.sv - receive enable sequencing, safe speed switching and frame statistics
module eth_rx_ctrl
  import eth_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int IDLE_GAP  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  input  logic [1:0]           cfg_speed,
  input  logic                 stat_clear,
  eth_rx_ctrl_if.slave         rx,
  output logic [1:0]           speed_active,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] stat_frames_good,
  output logic [CNT_WIDTH-1:0] stat_frames_bad,
  output logic [CNT_WIDTH-1:0] stat_fcs_err
);

  localparam int GAP_W = $clog2(IDLE_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(IDLE_GAP);

  state_t           state, state_n;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_ok;
  logic             in_frame;
  logic             frame_end;
  logic [1:0]       cfg_spd;
  logic             speed_match;
  logic             can_apply;
  logic             apply;

  assign frame_end   = rx.rx_tvalid && rx.rx_tlast;
  assign gap_ok      = (gap_cnt >= GAP_MAX);
  assign cfg_spd     = norm_speed(cfg_speed);
  assign speed_match = (cfg_spd == speed_active);
  assign can_apply   = !in_frame && gap_ok;
  assign busy        = (state != ST_RUN) && (state != ST_OFF);

  always_ff @(posedge clk) begin
    if (rst || rx.rx_dv) begin
      gap_cnt <= '0;
    end else if (gap_cnt < GAP_MAX) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // A new frame starting in the same cycle as the previous one ends wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame <= 1'b0;
    end else if (rx.start_packet) begin
      in_frame <= 1'b1;
    end else if (frame_end) begin
      in_frame <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    apply   = 1'b0;
    case (state)
      ST_OFF: begin
        apply = !speed_match && can_apply;
        if (cfg_enable) state_n = ST_ARM;
      end
      ST_ARM: begin
        apply = !speed_match && can_apply;
        if (!cfg_enable) begin
          state_n = ST_OFF;
        end else if (gap_ok && speed_match) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!cfg_enable || !speed_match) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (can_apply) begin
          apply   = 1'b1;
          state_n = cfg_enable ? ST_ARM : ST_OFF;
        end
      end
      default: state_n = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_OFF;
      rx.rx_cfg_enable <= 1'b0;
      speed_active     <= SPEED_1000;
      rx.mii_select    <= 1'b0;
    end else begin
      state            <= state_n;
      rx.rx_cfg_enable <= (state_n == ST_RUN);
      if (apply) begin
        speed_active  <= cfg_spd;
        rx.mii_select <= speed_is_mii(cfg_spd);
      end
    end
  end

  eth_clk_en_gen u_clk_en_gen (
    .clk        (clk),
    .rst        (rst),
    .ratio      (speed_ratio(speed_active)),
    .load       (apply),
    .clk_enable (rx.clk_enable)
  );

  // A clear that coincides with an increment keeps that event, so the counter reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames_good <= '0;
      stat_frames_bad  <= '0;
      stat_fcs_err     <= '0;
    end else begin
      if (stat_clear) begin
        stat_frames_good <= CNT_WIDTH'(frame_end && !rx.rx_tuser);
        stat_frames_bad  <= CNT_WIDTH'(frame_end && rx.rx_tuser);
        stat_fcs_err     <= CNT_WIDTH'(rx.error_bad_fcs);
      end else begin
        if (frame_end && !rx.rx_tuser) stat_frames_good <= stat_frames_good + 1'b1;
        if (frame_end && rx.rx_tuser)  stat_frames_bad  <= stat_frames_bad + 1'b1;
        if (rx.error_bad_fcs)          stat_fcs_err     <= stat_fcs_err + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// tb/tb_eth_rx_ctrl.sv - directed table and sequence checks for eth_rx_ctrl
module tb_eth_rx_ctrl;
  import eth_pkg::*;

  localparam int CW = 4;

  typedef struct {
    logic          tv;
    logic          tl;
    logic          tu;
    logic          fcs;
    logic          clr;
    logic [CW-1:0] eg;
    logic [CW-1:0] eb;
    logic [CW-1:0] ef;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic [1:0]    cfg_speed;
  logic          stat_clear;
  logic [1:0]    speed_active;
  logic          busy;
  logic [CW-1:0] stat_frames_good;
  logic [CW-1:0] stat_frames_bad;
  logic [CW-1:0] stat_fcs_err;

  int n_vec  = 0;
  int n_fail = 0;

  eth_rx_ctrl_if bus ();

  eth_rx_ctrl #(.CNT_WIDTH(CW), .IDLE_GAP(12)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_enable       (cfg_enable),
    .cfg_speed        (cfg_speed),
    .stat_clear       (stat_clear),
    .rx               (bus.slave),
    .speed_active     (speed_active),
    .busy             (busy),
    .stat_frames_good (stat_frames_good),
    .stat_frames_bad  (stat_frames_bad),
    .stat_fcs_err     (stat_fcs_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Clears one-cycle frame strobes after each edge; n = edges until target speed, 99 on timeout.
  task automatic wait_speed(input logic [1:0] target, output int n);
    n = 99;
    for (int i = 1; i <= 60; i++) begin
      tick();
      bus.rx_tvalid     = 1'b0;
      bus.rx_tlast      = 1'b0;
      bus.rx_tuser      = 1'b0;
      bus.error_bad_fcs = 1'b0;
      if (speed_active == target) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic good_frame();
    bus.rx_tvalid = 1'b1;
    bus.rx_tlast  = 1'b1;
    bus.rx_tuser  = 1'b0;
    tick();
    bus.rx_tvalid = 1'b0;
    bus.rx_tlast  = 1'b0;
  endtask

  vec_t vt[10];

  initial begin
    int  n;
    logic ok;

    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0};
    vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd1};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd2};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0};
    vt[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 4'd1};
    vt[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd1};

    // Reset held while a frame start is asserted, with a 100M request pending in OFF.
    rst = 1'b1; cfg_enable = 1'b0; cfg_speed = SPEED_100; stat_clear = 1'b0;
    bus.rx_dv = 1'b0; bus.rx_tvalid = 1'b0; bus.rx_tlast = 1'b0; bus.rx_tuser = 1'b0;
    bus.start_packet = 1'b1; bus.error_bad_fcs = 1'b0;
    tick(); tick();
    check("rst_rx_cfg_enable", bus.rx_cfg_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_speed", speed_active, SPEED_1000);
    check("rst_mii", bus.mii_select, 0);
    check("rst_clk_enable", bus.clk_enable, 1);
    check("rst_stats", {stat_frames_good, stat_frames_bad, stat_fcs_err}, 0);

    rst = 1'b0; bus.start_packet = 1'b0;
    wait_speed(SPEED_100, n);
    check("off_apply_latency", n, 13);
    check("off_apply_mii", bus.mii_select, 1);
    check("off_apply_busy", busy, 0);

    // Gigabit bring-up from reset.
    rst = 1'b1; cfg_speed = SPEED_1000; cfg_enable = 1'b1;
    tick();
    rst = 1'b0;
    n = 99; ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.clk_enable !== 1'b1) ok = 1'b0;
      if (bus.rx_cfg_enable) begin
        n = i;
        break;
      end
    end
    check("arm_to_run_latency", n, 13);
    check("gig_clk_enable_const", ok, 1);
    check("gig_busy", busy, 0);

    // Speed change requested in the middle of a frame.
    bus.rx_dv = 1'b1; bus.start_packet = 1'b1;
    tick();
    bus.start_packet = 1'b0; cfg_speed = SPEED_100;
    tick();
    check("stop_rx_cfg_enable", bus.rx_cfg_enable, 0);
    check("stop_busy", busy, 1);
    repeat (4) tick();
    check("stop_hold_speed", speed_active, SPEED_1000);
    bus.rx_dv = 1'b0; bus.rx_tvalid = 1'b1; bus.rx_tlast = 1'b1;
    wait_speed(SPEED_100, n);
    check("stop_apply_latency", n, 13);
    check("stop_apply_mii", bus.mii_select, 1);
    ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (bus.clk_enable !== (i % 5 == 0)) ok = 1'b0;
      tick();
    end
    check("div5_pattern", ok, 1);
    check("rerun_rx_cfg_enable", bus.rx_cfg_enable, 1);

    // Short idle gaps during STOP must not allow the switch back to gigabit.
    cfg_speed = SPEED_1000;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.rx_dv = ((i / 8) % 2 == 0);
      tick();
      if (speed_active !== SPEED_100) ok = 1'b0;
    end
    check("toggle_no_apply", ok, 1);
    check("toggle_busy", busy, 1);
    bus.rx_dv = 1'b0;
    wait_speed(SPEED_1000, n);
    check("toggle_apply_latency", n, 13);
    check("toggle_mii", bus.mii_select, 0);

    // Statistics table.
    for (int i = 0; i < 10; i++) begin
      bus.rx_tvalid = vt[i].tv; bus.rx_tlast = vt[i].tl; bus.rx_tuser = vt[i].tu;
      bus.error_bad_fcs = vt[i].fcs; stat_clear = vt[i].clr;
      tick();
      bus.rx_tvalid = 1'b0; bus.rx_tlast = 1'b0; bus.rx_tuser = 1'b0;
      bus.error_bad_fcs = 1'b0; stat_clear = 1'b0;
      check($sformatf("vec%0d_good", i), stat_frames_good, vt[i].eg);
      check($sformatf("vec%0d_bad", i), stat_frames_bad, vt[i].eb);
      check($sformatf("vec%0d_fcs", i), stat_fcs_err, vt[i].ef);
    end

    // Counter wrap at 2^CW.
    stat_clear = 1'b1; tick(); stat_clear = 1'b0;
    repeat (15) good_frame();
    check("wrap_pre", stat_frames_good, 15);
    good_frame();
    check("wrap_post", stat_frames_good, 0);
    check("wrap_bad", stat_frames_bad, 0);

    good_frame();
    rst = 1'b1; tick(); rst = 1'b0;
    check("final_rst_good", stat_frames_good, 0);
    check("final_rst_rx_cfg_enable", bus.rx_cfg_enable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
